// File: rtl/led_matrix_scan.sv
// ---------------------------------------------------------------------------
// led_matrix_scan
//
// Time-multiplexed row scanner for the 4x4 mole LED matrix of the
// whack-a-mole board. It is the output-side counterpart of the keypad scanner.
//
// Game control hands over a 16-bit mole map through a valid/ready handshake.
// The map lands in a pending buffer and is copied to the shadow (displayed)
// buffer only at a frame boundary, so the display never tears. Each row period
// starts with a blanking interval that suppresses ghosting. After that the
// selected row is pulled low and its four column bits are driven high.
//
// Optional feature (macro LED_MATRIX_BLINK_EN):
//   Adds the blink_mask input and the BLINK_SHIFT parameter. The mask travels
//   with the map through pending and shadow. While bit BLINK_SHIFT of an
//   internal frame counter is set, masked LEDs are forced off.
//
// Parameters:
//   ROW_CYC      clk cycles per row period (> BLANK_CYC)
//   BLANK_CYC    blank cycles at the start of each row period (>= 1)
//   CNT_W        row-period counter width (2^CNT_W >= ROW_CYC)
//   BLINK_SHIFT  frame-counter bit that gates blinking (blink build only)
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   mole_map     [4r+3:4r] = row r, columns 0..3, 1 = LED on
//   frame_valid  mole_map is valid this cycle
//   blink_mask   per-LED blink enable (blink build only)
//   frame_ready  pending buffer empty, a frame can be accepted
//   row_out      active-low one-hot row select (1111 = all off)
//   col_out      active-high column drive
//   row_idx      index of the current row period
//   frame_done   one-cycle pulse on the last cycle of row 3
// ---------------------------------------------------------------------------
module led_matrix_scan #(
    parameter int ROW_CYC   = 250000,
    parameter int BLANK_CYC = 2500,
    parameter int CNT_W     = 20
`ifdef LED_MATRIX_BLINK_EN
    ,
    parameter int BLINK_SHIFT = 4
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mole_map,
    input  logic        frame_valid,
`ifdef LED_MATRIX_BLINK_EN
    input  logic [15:0] blink_mask,
`endif
    output logic        frame_ready,
    output logic [3:0]  row_out,
    output logic [3:0]  col_out,
    output logic [1:0]  row_idx,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ROW_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    // Column nibble of one row out of a 16-bit map.
    function automatic logic [3:0] row_cols(input logic [15:0] map,
                                            input logic [1:0]  row);
        return map[{row, 2'b00} +: 4];
    endfunction

    // Active-low one-hot row select.
    function automatic logic [3:0] row_sel(input logic [1:0] row);
        return ~(4'b0001 << row);
    endfunction

    // Scan state
    phase_t           phase;
    phase_t           phase_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       row_next;
    logic             row_wrap;
    logic             boundary;

    // Frame buffers
    logic [15:0] shadow;
    logic [15:0] shadow_next;
    logic [15:0] pending;
    logic        pend_full;
    logic        accept;
    logic        swap;

    // Registered-output next values
    logic [3:0] row_out_next;
    logic [3:0] col_out_next;
    logic       frame_done_next;
    logic [3:0] blink_cols;

`ifdef LED_MATRIX_BLINK_EN
    logic [15:0]          blink_shadow;
    logic [15:0]          blink_shadow_next;
    logic [15:0]          blink_pending;
    logic [BLINK_SHIFT:0] frame_cnt;
    logic [BLINK_SHIFT:0] frame_cnt_next;
`endif

    // frame_ready comes straight from a flop, so there is no path from the
    // producer's signals back to its own ready input.
    assign frame_ready = ~pend_full;
    assign accept      = frame_valid & ~pend_full;
    assign row_wrap    = (cnt == CNT_LAST);
    assign boundary    = row_wrap & (row_idx == 2'd3);
    // accept needs pending empty and swap needs it full, so the two never
    // coincide. A frame accepted on the boundary waits a whole frame.
    assign swap        = boundary & pend_full;

    // ------------------------------------------------------------------
    // Next-state logic: counter, row index, phase and display buffer
    // ------------------------------------------------------------------
    always_comb begin
        cnt_next    = row_wrap ? '0 : cnt + 1'b1;
        row_next    = row_wrap ? row_idx + 2'd1 : row_idx;
        phase_next  = (cnt_next < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
        shadow_next = swap ? pending : shadow;
    end

`ifdef LED_MATRIX_BLINK_EN
    always_comb begin
        blink_shadow_next = swap ? blink_pending : blink_shadow;
        frame_cnt_next    = boundary ? frame_cnt + 1'b1 : frame_cnt;
        blink_cols        = frame_cnt_next[BLINK_SHIFT]
                            ? row_cols(blink_shadow_next, row_next) : 4'b0000;
    end
`else
    assign blink_cols = 4'b0000;
`endif

    // ------------------------------------------------------------------
    // Output decode of the next state. Registering these values lines the
    // pins up with cnt/row_idx of the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        row_out_next    = 4'b1111;
        col_out_next    = 4'b0000;
        frame_done_next = (cnt_next == CNT_LAST) && (row_next == 2'd3);
        if (phase_next == PH_DRIVE) begin
            row_out_next = row_sel(row_next);
            col_out_next = row_cols(shadow_next, row_next) & ~blink_cols;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase      <= PH_BLANK;
            cnt        <= '0;
            row_idx    <= 2'd0;
            row_out    <= 4'b1111;
            col_out    <= 4'b0000;
            frame_done <= 1'b0;
        end else begin
            phase      <= phase_next;
            cnt        <= cnt_next;
            row_idx    <= row_next;
            row_out    <= row_out_next;
            col_out    <= col_out_next;
            frame_done <= frame_done_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame buffers. Reset discards any pending frame and clears the
    // display.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow    <= 16'h0000;
            pending   <= 16'h0000;
            pend_full <= 1'b0;
        end else begin
            shadow <= shadow_next;
            if (accept) begin
                pending   <= mole_map;
                pend_full <= 1'b1;
            end else if (swap) begin
                pend_full <= 1'b0;
            end
        end
    end

`ifdef LED_MATRIX_BLINK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_shadow  <= 16'h0000;
            blink_pending <= 16'h0000;
            frame_cnt     <= '0;
        end else begin
            blink_shadow <= blink_shadow_next;
            frame_cnt    <= frame_cnt_next;
            if (accept) begin
                blink_pending <= blink_mask;
            end
        end
    end
`endif

    // phase only documents the scan state; the pins decode from phase_next.
    logic phase_unused;
    assign phase_unused = (phase == PH_DRIVE);

endmodule

// File: tb/tb_led_matrix_scan.sv
module tb_led_matrix_scan;

    localparam int ROW_CYC   = 10;
    localparam int BLANK_CYC = 2;
    localparam int CNT_W     = 4;
    localparam int FRAME_CYC = 4 * ROW_CYC;
`ifdef LED_MATRIX_BLINK_EN
    localparam int BLINK_SHIFT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mole_map = 16'h0000;
    logic        frame_valid = 1'b0;
    logic [15:0] blink_mask = 16'h0000;
    logic        frame_ready;
    logic [3:0]  row_out;
    logic [3:0]  col_out;
    logic [1:0]  row_idx;
    logic        frame_done;

    always #5 clk = ~clk;

    led_matrix_scan #(
        .ROW_CYC   (ROW_CYC),
        .BLANK_CYC (BLANK_CYC),
        .CNT_W     (CNT_W)
`ifdef LED_MATRIX_BLINK_EN
        ,
        .BLINK_SHIFT (BLINK_SHIFT)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mole_map    (mole_map),
        .frame_valid (frame_valid),
`ifdef LED_MATRIX_BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .frame_ready (frame_ready),
        .row_out     (row_out),
        .col_out     (col_out),
        .row_idx     (row_idx),
        .frame_done  (frame_done)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: time since reset, the displayed map, and a one-deep
    // pending slot. Everything else follows from t.
    int          t;
    logic [15:0] m_shadow, m_pend, m_bshadow, m_bpend;
    bit          m_full;

    task automatic model_reset();
        t         = 0;
        m_shadow  = 16'h0000;
        m_pend    = 16'h0000;
        m_bshadow = 16'h0000;
        m_bpend   = 16'h0000;
        m_full    = 1'b0;
    endtask

    task automatic check_outputs();
        int          pos, row, frame;
        logic [3:0]  exp_row, exp_col, blk;
        logic [15:0] sh;
        pos   = t % ROW_CYC;
        row   = (t / ROW_CYC) % 4;
        frame = t / FRAME_CYC;
        blk   = 4'b0000;
`ifdef LED_MATRIX_BLINK_EN
        sh = m_bshadow;
        if (((frame >> BLINK_SHIFT) & 1) == 1) blk = sh[row*4 +: 4];
`endif
        sh = m_shadow;
        if (pos < BLANK_CYC) begin
            exp_row = 4'b1111;
            exp_col = 4'b0000;
        end else begin
            exp_row = ~(4'b0001 << row);
            exp_col = sh[row*4 +: 4] & ~blk;
        end
        chk($sformatf("row_out@%0d", t), 32'(row_out), 32'(exp_row));
        chk($sformatf("col_out@%0d", t), 32'(col_out), 32'(exp_col));
        chk($sformatf("row_idx@%0d", t), 32'(row_idx), 32'(row));
        chk($sformatf("frame_ready@%0d", t), 32'(frame_ready), 32'(!m_full));
        chk($sformatf("frame_done@%0d", t), 32'(frame_done),
            32'((t % FRAME_CYC) == FRAME_CYC - 1));
    endtask

    // One clock cycle: called at a negedge; checks the current outputs,
    // drives this cycle's inputs, advances the model across the posedge.
    task automatic cycle(input bit fv, input logic [15:0] map, input logic [15:0] bm);
        bit acc;
        check_outputs();
        frame_valid = fv;
        mole_map    = map;
        blink_mask  = bm;
        acc = fv && !m_full;
        if ((t % FRAME_CYC) == FRAME_CYC - 1 && m_full) begin
            m_shadow  = m_pend;
            m_bshadow = m_bpend;
            m_full    = 1'b0;
        end
        if (acc) begin
            m_pend  = map;
            m_bpend = bm;
            m_full  = 1'b1;
        end
        t++;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_row_out", 32'(row_out), 32'hF);
        chk("reset_col_out", 32'(col_out), 32'h0);
        chk("reset_ready", 32'(frame_ready), 32'h1);
        chk("reset_done", 32'(frame_done), 32'h0);
        rst = 1'b1;

        // Directed frame sequence
        for (int i = 0; i < 200; i++) begin
            if (t == 5)                  cycle(1'b1, 16'hA5C3, 16'h000F);
            else if (t >= 20 && t < 30)  cycle(1'b1, 16'h1111, 16'h0000);
            else if (t == 45)            cycle(1'b1, 16'hFFFF, 16'h000F);
            else if (t == 119)           cycle(1'b1, 16'h3C3C, 16'h00F0);
            else                         cycle(1'b0, 16'(($urandom)), 16'(($urandom)));
        end

        // Random producer
        for (int i = 0; i < 1500; i++)
            cycle(($urandom_range(0, 7) == 0), 16'($urandom), 16'($urandom));

        // Run into the DRIVE phase of row 2, then reset mid-operation
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            if (((t / ROW_CYC) % 4) == 2 && (t % ROW_CYC) == BLANK_CYC + 3) break;
            cycle(1'b0, 16'h0000, 16'h0000);
        end
        chk("pre_reset_row", 32'(row_idx), 32'd2);
        rst = 1'b0;
        #1;
        chk("mid_reset_row_out", 32'(row_out), 32'hF);
        chk("mid_reset_col_out", 32'(col_out), 32'h0);
        chk("mid_reset_ready", 32'(frame_ready), 32'h1);
        chk("mid_reset_row_idx", 32'(row_idx), 32'h0);
        chk("mid_reset_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Blank display after reset, then a few more random frames
        for (int i = 0; i < 60; i++) cycle(1'b0, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
